// File: rtl/dmem_responder.sv
// Purpose: single-port data memory slave with byte/half/word access, sign/zero extension and range/size faults.
// Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accept edge; one access in flight at a time.
// Backpressure: req_ready is low outside IDLE; the response is held stable until rsp_ready is seen high.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of aligning down.
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_rw,
    input  logic [1:0]  req_size,
    input  logic        req_unsign,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  wait_cnt;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rw_q;
    logic        unsign_q;
    logic [1:0]  size_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_rw;
    logic        cur_unsign;
    logic [1:0]  cur_size;
    logic [31:0] offset;
    logic [AW-1:0] word_idx;
    logic        misalign;
    logic        fault;
    logic [3:0]  lane_en;
    logic [31:0] lane_dat;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;

    // Memory is touched only on the edge that moves into RESP. With zero wait
    // states that is the accept edge itself, so the live request is used.
    assign enter_resp = (accept && (WAIT_INIT == 4'd0)) ||
                        ((state == ST_WAIT) && (wait_cnt == 4'd1));

    assign cur_addr   = (state == ST_IDLE) ? req_addr   : addr_q;
    assign cur_wdata  = (state == ST_IDLE) ? req_wdata  : wdata_q;
    assign cur_rw     = (state == ST_IDLE) ? req_rw     : rw_q;
    assign cur_unsign = (state == ST_IDLE) ? req_unsign : unsign_q;
    assign cur_size   = (state == ST_IDLE) ? req_size   : size_q;

    // Unsigned offset makes addresses below the base wrap high and fault too.
    assign offset   = cur_addr - BASE_ADDR;
    assign word_idx = offset[AW+1:2];
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{cur_addr[1:0], 3'b000} +: 8];
    assign rd_half  = rd_word[{cur_addr[1], 4'b0000} +: 16];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((cur_size == 2'd1) && cur_addr[0]) ||
                      ((cur_size == 2'd2) && (cur_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign fault = (offset >= SPAN) || (cur_size == 2'd3) || misalign;

    // Lane enables and lane-replicated write data; half/word ignore low address bits.
    always_comb begin
        lane_en  = 4'b0000;
        lane_dat = 32'h0;
        case (cur_size)
            2'd0: begin
                lane_en  = 4'b0001 << cur_addr[1:0];
                lane_dat = {4{cur_wdata[7:0]}};
            end
            2'd1: begin
                lane_en  = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_dat = {2{cur_wdata[15:0]}};
            end
            2'd2: begin
                lane_en  = 4'b1111;
                lane_dat = cur_wdata;
            end
            default: begin
                lane_en  = 4'b0000;
                lane_dat = 32'h0;
            end
        endcase
    end

    // Extend narrow reads to 32 bits; word reads pass through unchanged.
    always_comb begin
        rd_ext = rd_word;
        case (cur_size)
            2'd0:    rd_ext = cur_unsign ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'd1:    rd_ext = cur_unsign ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = rd_word;
        endcase
    end

    // Request capture on accept; downstream decode reads these during WAIT.
    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rw_q     <= req_rw;
            unsign_q <= req_unsign;
            size_q   <= req_size;
        end
    end

    // Control FSM and response registers; reset drops any in-flight access.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (WAIT_INIT == 4'd0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (enter_resp) begin
                rsp_err   <= fault;
                rsp_rdata <= (fault || cur_rw) ? 32'h0 : rd_ext;
            end
        end
    end

    // Lane-masked write commit; storage itself is never cleared by reset.
    always_ff @(posedge clock) begin
        if (reset && enter_resp && cur_rw && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= lane_dat[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose: randomized and directed bench for dmem_responder against a byte-array reference model.
// Latency: checks rsp_valid arrives exactly WAIT_CYCLES+1 cycles after each accept edge.
// Backpressure: holds rsp_ready low for random stretches and checks the response stays stable.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 256;
    localparam int          WAITC = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_rw = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsign = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_bytes [4*DEPTH];

    dmem_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_rw     (req_rw),
        .req_size   (req_size),
        .req_unsign (req_unsign),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: memory as a flat byte array, accesses as byte counts.
    function automatic void model(input logic [31:0] a, input logic rw, input logic [1:0] sz,
                                  input logic us, input logic [31:0] wd,
                                  output logic [31:0] erd, output logic eerr);
        logic [31:0] off;
        logic [31:0] v;
        int n;
        int base;
        off  = a - BASE;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        eerr = (off >= 32'(4*DEPTH)) || (sz == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (sz == 2'd1 && (a % 2) != 0) eerr = 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) eerr = 1'b1;
`endif
        erd = 32'h0;
        if (eerr) return;
        base = (int'(off) / n) * n;
        if (rw) begin
            for (int i = 0; i < n; i++) ref_bytes[base+i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base+i]) << (8*i));
            if (n < 4 && !us && v[8*n-1]) v = v + (32'hFFFF_FFFF << (8*n));
            erd = v;
        end
    endfunction

    // One complete access starting and ending at a falling edge in IDLE.
    task automatic xact(input logic [31:0] a, input logic rw, input logic [1:0] sz, input logic us,
                        input logic [31:0] wd, input int stall,
                        output logic [31:0] grd, output logic gerr);
        logic [31:0] erd;
        logic        eerr;
        int          n;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_addr   = a;
        req_rw     = rw;
        req_size   = sz;
        req_unsign = us;
        req_wdata  = wd;
        req_valid  = 1'b1;
        rsp_ready  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rw     = 1'($urandom);
        req_size   = 2'($urandom);
        req_unsign = 1'($urandom);
        n = 1;
        while (!rsp_valid && n < 40) begin
            chk("req_ready_wait", 32'(req_ready), 32'd0);
            @(negedge clock);
            n++;
        end
        chk("latency", 32'(n), 32'(WAITC + 1));
        model(a, rw, sz, us, wd, erd, eerr);
        grd  = rsp_rdata;
        gerr = rsp_err;
        chk("rsp_rdata", rsp_rdata, erd);
        chk("rsp_err", 32'(rsp_err), 32'(eerr));
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, grd);
            chk("hold_err", 32'(rsp_err), 32'(gerr));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] grd;
        logic        gerr;
        logic [31:0] wd;
        logic [31:0] a;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Give every word a known value
        for (int w = 0; w < DEPTH; w++) begin
            wd = $urandom;
            xact(BASE + 32'(4*w), 1'b1, 2'd2, 1'b0, wd, 0, grd, gerr);
        end

        // Word write/read
        xact(32'h0100_0004, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, grd, gerr);
        chk("w_rdata_zero", grd, 32'h0);
        xact(32'h0100_0004, 1'b0, 2'd2, 1'b0, 32'h0, 0, grd, gerr);
        chk("word_read", grd, 32'hDEAD_BEEF);

        // Byte write, signed byte reads, merged word
        xact(32'h0100_0006, 1'b1, 2'd0, 1'b0, 32'h0000_0011, 0, grd, gerr);
        xact(32'h0100_0007, 1'b0, 2'd0, 1'b0, 32'h0, 0, grd, gerr);
        chk("sbyte7", grd, 32'hFFFF_FFDE);
        xact(32'h0100_0006, 1'b0, 2'd0, 1'b0, 32'h0, 0, grd, gerr);
        chk("sbyte6", grd, 32'h0000_0011);
        xact(32'h0100_0004, 1'b0, 2'd2, 1'b0, 32'h0, 0, grd, gerr);
        chk("merged_word", grd, 32'hDE11_BEEF);

        // Long backpressure
        xact(32'h0100_0004, 1'b0, 2'd2, 1'b0, 32'h0, 5, grd, gerr);

        // Faults: out of range, size 3, below base, aliasing write
        xact(32'h0100_0400, 1'b0, 2'd2, 1'b0, 32'h0, 0, grd, gerr);
        chk("oor_err", 32'(gerr), 32'd1);
        xact(32'h0100_0000, 1'b0, 2'd3, 1'b0, 32'h0, 0, grd, gerr);
        chk("size3_err", 32'(gerr), 32'd1);
        xact(32'h00FF_FFFC, 1'b1, 2'd2, 1'b0, 32'hA5A5_A5A5, 0, grd, gerr);
        xact(32'h0100_0400, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 0, grd, gerr);
        xact(32'h0100_0000, 1'b1, 2'd3, 1'b0, 32'h1111_1111, 0, grd, gerr);
        xact(32'h0100_0000, 1'b0, 2'd2, 1'b0, 32'h0, 0, grd, gerr);
        xact(32'h0100_03FC, 1'b0, 2'd2, 1'b0, 32'h0, 0, grd, gerr);

        // Reset caught in WAIT drops the write
        req_addr  = 32'h0100_0008;
        req_rw    = 1'b1;
        req_size  = 2'd2;
        req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        chk("mid_wait_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'h0);
        chk("mid_rst_err", 32'(rsp_err), 32'd0);
        repeat (4) @(negedge clock);
        chk("mid_rst_quiet", 32'(rsp_valid), 32'd0);
        xact(32'h0100_0008, 1'b0, 2'd2, 1'b0, 32'h0, 0, grd, gerr);

        // Misaligned half read
        xact(32'h0100_0005, 1'b0, 2'd1, 1'b1, 32'h0, 0, grd, gerr);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("half_mis_err", 32'(gerr), 32'd1);
        chk("half_mis_rdata", grd, 32'h0);
`else
        chk("half_mis_rdata", grd, 32'h0000_BEEF);
        chk("half_mis_err", 32'(gerr), 32'd0);
`endif

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            a = BASE + 32'($urandom_range(0, 4*DEPTH - 1));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            xact(a, 1'($urandom), 2'($urandom), 1'($urandom), $urandom,
                 int'($urandom_range(0, 3)), grd, gerr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0100_0000, byte address of the first memory word.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, number of wait states per access (0..15).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  initiator presents a request.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_rw  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-011 SHALL have port req_unsign  input  1  1 = zero-extend read data, 0 = sign-extend it.
REQ-012 SHALL have port req_wdata  input  32  write data, right-justified.
REQ-013 SHALL have port rsp_valid  output  1  response is available.
REQ-014 SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-015 SHALL have port rsp_rdata  output  32  extended read data; 0 for writes and errors.
REQ-016 SHALL have port rsp_err  output  1  access faulted.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT and RESP; req_ready = (state == IDLE).
REQ-018 SHALL accept a request on a cycle with req_valid && req_ready and capture addr, rw, size, unsign and wdata.
REQ-019 SHALL, on accept, go to WAIT loaded with WAIT_CYCLES, or go directly to RESP when WAIT_CYCLES = 0.
REQ-020 SHALL decrement the WAIT counter each cycle and transition WAIT->RESP on the cycle the counter reads 1.
REQ-021 SHALL assert rsp_valid exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-022 SHALL commit writes and sample read data on the transition into RESP, never earlier.
REQ-023 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE the following cycle.
REQ-024 SHALL keep req_ready low in WAIT and RESP, so peak throughput is one access per WAIT_CYCLES+2 cycles.
REQ-025 SHALL use little-endian byte lanes.
- Byte: lane addr[1:0].
- Half: lanes {addr[1],1} and {addr[1],0}.
- Word: all four lanes.
REQ-026 SHALL modify only the addressed lanes on a write; all other lanes are preserved.
REQ-027 SHALL extend byte and half reads to 32 bits: zero-extend when req_unsign = 1, sign-extend when req_unsign = 0; word reads are not extended.
REQ-028 SHALL signal rsp_err = 1, suppress the write and return rsp_rdata = 0 when either condition holds:
- req_addr - BASE_ADDR >= 4*DEPTH_WORDS (unsigned compare, so addresses below BASE_ADDR also fault);
- req_size = 3.
REQ-029 SHALL give rsp_rdata = 0 and rsp_err = 0 for every write that succeeds.
REQ-030 SHALL drive rsp_valid = 0 outside RESP.

Reset
REQ-031 SHALL, when reset = 0 at a clock edge, enter IDLE, clear the WAIT counter and force rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; req_ready = 1 from the first cycle after reset releases.
REQ-032 SHALL drop a request caught mid-operation by reset (in WAIT): the pending write is not committed.
REQ-033 SHALL NOT clear memory contents on reset.

Configuration
REQ-034 SHALL honour macro DMEM_MISALIGN_TRAP_EN.
- Defined: half access with addr[0] = 1, or word access with addr[1:0] != 0, returns rsp_err = 1, writes nothing and returns rsp_rdata = 0.
- Undefined: the offending low address bits are ignored (half aligns down to addr[1]; word aligns down to addr[1:0] = 0) and rsp_err = 0.

Verification
REQ-035 SHALL cover: word write 0xDEADBEEF at 0x01000004, then word read of the same address -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid exactly 3 cycles after each accept.
REQ-036 SHALL cover: after REQ-035, byte write 0x11 at 0x01000006, then signed byte reads at 0x01000007 and 0x01000006 -> 0xFFFFFFDE and 0x00000011; word read -> 0xDE11BEEF.
REQ-037 SHALL cover: rsp_ready held low for 5 cycles during RESP -> rsp_valid/rsp_rdata stable; req_ready = 0 throughout.
REQ-038 SHALL cover: read at 0x01000400 and a size-3 read at 0x01000000 -> rsp_err = 1, rsp_rdata = 0, memory unchanged.
REQ-039 SHALL cover: word write 0x12345678 at 0x01000008 with reset asserted in WAIT -> IDLE next cycle; a later read returns the old contents.
REQ-040 SHALL cover: half read at 0x01000005 -> rsp_err = 1 with DMEM_MISALIGN_TRAP_EN, half from 0x01000004 without it.
